// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared state type and width helper for stream_mux
package stream_mux_pkg;

  typedef enum logic {IDLE, LOCKED} mux_state_e;

  function automatic int sel_w(int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - fixed-priority or round-robin grant with rotating pointer
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int CH = 4,
  parameter int RR = 1,
  localparam int SW = sel_w(CH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH-1:0] req,
  input  logic          advance,
  output logic [CH-1:0] grant,
  output logic [SW-1:0] grant_idx
);

  logic [SW-1:0] ptr_q, ptr_d;
  int            base;
  int            idx;
  logic          found;

  // Scan from the pointer (or from 0 in fixed-priority mode), wrapping modulo CH.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    base      = (RR != 0) ? int'(ptr_q) : 0;
    for (int k = 0; k < CH; k++) begin
      idx = (base + k) % CH;
      if (!found && req[SW'(idx)]) begin
        found             = 1'b1;
        grant[SW'(idx)]   = 1'b1;
        grant_idx         = SW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if ((RR != 0) && (CH > 1) && advance) begin
      ptr_d = (grant_idx == SW'(CH - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/stream_mux.sv
// rtl/stream_mux.sv - registered N-to-1 stream mux with arbitration
// Packet lock (no interleaving within a packet) is built with STREAM_MUX_PKT_LOCK_EN.
module stream_mux
  import stream_mux_pkg::*;
#(
  parameter int DW = 8,
  parameter int CH = 4,
  parameter int RR = 1,
  localparam int SW = sel_w(CH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data [CH],
  input  logic [CH-1:0] in_valid,
  input  logic [CH-1:0] in_last,
  output logic [CH-1:0] in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic          out_last,
  output logic [SW-1:0] out_sel,
  input  logic          out_ready
);

  logic [CH-1:0] eligible;
  logic [CH-1:0] grant;
  logic [SW-1:0] grant_idx;
  logic          load;
  logic          xfer;
  logic          xfer_last;
  logic          advance;
  logic [DW-1:0] xfer_data;
  mux_state_e    state;

  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic [SW-1:0] out_sel_q, out_sel_d;

`ifdef STREAM_MUX_PKT_LOCK_EN
  mux_state_e    state_q, state_d;
  logic [SW-1:0] lock_ch_q, lock_ch_d;

  assign state    = state_q;
  assign eligible = (state_q == LOCKED) ? (in_valid & (CH'(1) << lock_ch_q)) : in_valid;

  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    case (state_q)
      IDLE: begin
        if (xfer && !xfer_last) begin
          state_d   = LOCKED;
          lock_ch_d = grant_idx;
        end
      end
      LOCKED: begin
        if (xfer && xfer_last) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lock_ch_q <= '0;
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
    end
  end
`else
  assign state    = IDLE;
  assign eligible = in_valid;
`endif

  rr_arbiter #(
    .CH (CH),
    .RR (RR)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (eligible),
    .advance   (advance),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign load     = !out_valid_q || out_ready;
  assign in_ready = (rst_n && load) ? grant : '0;
  assign xfer     = |in_ready;
  assign advance  = xfer && (state == IDLE);

  // One-hot select keeps in_data on a register-only path.
  always_comb begin
    xfer_data = '0;
    for (int i = 0; i < CH; i++) begin
      if (grant[i]) begin
        xfer_data = in_data[i];
      end
    end
  end
  assign xfer_last = |(in_last & grant);

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
    if (xfer) begin
      out_data_d  = xfer_data;
      out_valid_d = 1'b1;
      out_last_d  = xfer_last;
      out_sel_d   = grant_idx;
    end else if (load) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_mux.sv
// tb/tb_stream_mux.sv - scoreboard bench for stream_mux (round-robin and fixed-priority instances)
module tb_stream_mux;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tb_data [4];
  logic [3:0] tb_valid, tb_last, in_ready;
  logic [7:0] out_data;
  logic       out_valid, out_last, tb_ready;
  logic [1:0] out_sel;

  logic [7:0] fp_data [4];
  logic [3:0] fp_valid, fp_last, fp_ready;
  logic [7:0] fp_out_data;
  logic       fp_out_valid, fp_out_last, fp_out_ready;
  logic [1:0] fp_out_sel;

  beat_t      src_q [4][$];
  beat_t      exp_q [4][$];
  int         order_q [$];
  logic [3:0] en;
  logic [3:0] last_rdy;
  int         last_xfer_ch;
  logic [7:0] last_xfer_data;
  int         checks = 0;
  int         passes = 0;
  beat_t      mon_e;
  int         mon_s;

  always #5 clk = ~clk;

  stream_mux #(.DW(8), .CH(4), .RR(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(tb_data), .in_valid(tb_valid), .in_last(tb_last),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_sel(out_sel), .out_ready(tb_ready)
  );

  stream_mux #(.DW(8), .CH(4), .RR(0)) u_fp (
    .clk(clk), .rst_n(rst_n), .in_data(fp_data), .in_valid(fp_valid), .in_last(fp_last),
    .in_ready(fp_ready), .out_data(fp_out_data), .out_valid(fp_out_valid), .out_last(fp_out_last),
    .out_sel(fp_out_sel), .out_ready(fp_out_ready)
  );

  // Scoreboard: every output transfer must match the next expected beat of its channel.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && tb_ready === 1'b1) begin
      checks++;
      if ($isunknown(out_sel) || exp_q[out_sel].size() == 0) begin
        $display("FAIL sb_unexpected: got sel=%0d data=%h, required no beat", out_sel, out_data);
      end else begin
        mon_e = exp_q[out_sel].pop_front();
        if (out_data !== mon_e.data || out_last !== mon_e.last)
          $display("FAIL sb_beat ch%0d: got data=%h last=%b, required data=%h last=%b",
                   out_sel, out_data, out_last, mon_e.data, mon_e.last);
        else passes++;
      end
      if (order_q.size() > 0) begin
        mon_s = order_q.pop_front();
        checks++;
        if (int'(out_sel) !== mon_s) $display("FAIL sb_order: got sel=%0d, required %0d", out_sel, mon_s);
        else passes++;
      end
    end
    if (rst_n === 1'b1 && out_valid === 1'b1 && tb_ready === 1'b0) begin
      checks++;
      if (in_ready !== 4'b0) $display("FAIL backpressure_ready: got %b, required 0000", in_ready);
      else passes++;
    end
  end

  function automatic int exp_left();
    int n = order_q.size();
    for (int i = 0; i < 4; i++) n += exp_q[i].size();
    return n;
  endfunction

  task automatic push_beat(input int ch, input logic [7:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    src_q[ch].push_back(b);
    exp_q[ch].push_back(b);
  endtask

  task automatic step();
    for (int i = 0; i < 4; i++) begin
      if (en[i] && src_q[i].size() > 0) begin
        tb_valid[i] = 1'b1;
        tb_data[i]  = src_q[i][0].data;
        tb_last[i]  = src_q[i][0].last;
      end else begin
        tb_valid[i] = 1'b0;
        tb_data[i]  = 8'h00;
        tb_last[i]  = 1'b0;
      end
    end
    @(negedge clk);
    last_rdy = in_ready;
    @(posedge clk);
    #1;
    last_xfer_ch = -1;
    for (int i = 0; i < 4; i++) begin
      if (last_rdy[i] && tb_valid[i]) begin
        last_xfer_ch   = i;
        last_xfer_data = src_q[i][0].data;
        void'(src_q[i].pop_front());
      end
    end
  endtask

  task automatic drain_and_check(input string name);
    int n = 0;
    en = 4'hF;
    while (exp_left() > 0 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (exp_left() != 0) $display("FAIL %s_drain: got %0d beats outstanding, required 0", name, exp_left());
    else passes++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tb_valid = '0; tb_last = '0; en = '0; tb_ready = 1'b1;
    fp_valid = '0; fp_last = '0; fp_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tb_data[i] = 8'h00;
      fp_data[i] = 8'h00;
      src_q[i].delete();
      exp_q[i].delete();
    end
    order_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tb_ready = 1'b1;
    tb_valid = 4'hF;
    tb_last = 4'hF;
    for (int i = 0; i < 4; i++) tb_data[i] = 8'h5A;
    @(negedge clk);
    checks++;
    if (in_ready !== 4'b0) $display("FAIL reset_in_ready: got %b, required 0000", in_ready);
    else passes++;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0 || out_sel !== 2'd0)
      $display("FAIL reset_outputs: got v=%b d=%h l=%b s=%0d, required all 0", out_valid, out_data, out_last, out_sel);
    else passes++;
    do_reset();
  endtask

  task automatic test_single_channel();
    do_reset();
    en = 4'hF;
    push_beat(2, 8'h11, 1'b0);
    push_beat(2, 8'h22, 1'b0);
    push_beat(2, 8'h33, 1'b1);
    for (int k = 0; k < 3; k++) order_q.push_back(2);
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (last_xfer_ch != 2 || out_valid !== 1'b1 || out_data !== last_xfer_data || out_sel !== 2'd2)
        $display("FAIL single_latency beat%0d: got xfer_ch=%0d v=%b d=%h s=%0d, required ch2 v=1 d=%h s=2",
                 k, last_xfer_ch, out_valid, out_data, out_sel, last_xfer_data);
      else passes++;
    end
    drain_and_check("single");
  endtask

  task automatic test_round_robin();
    do_reset();
    en = 4'hF;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        push_beat(i, 8'hA0 + 8'(i), 1'b1);
        order_q.push_back(i);
      end
    end
    for (int k = 0; k < 8; k++) step();
    checks++;
    if (src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size() != 0)
      $display("FAIL rr_throughput: got sources not drained after 8 cycles, required 1 beat/cycle");
    else passes++;
    drain_and_check("rr");
  endtask

  task automatic test_fixed_priority();
    do_reset();
    for (int i = 0; i < 4; i++) fp_data[i] = 8'h40 + 8'(i);
    fp_last = 4'hF;
    fp_valid = 4'b1010;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (fp_ready !== 4'b0010) $display("FAIL fp_ready cycle%0d: got %b, required 0010", k, fp_ready);
      else passes++;
      @(posedge clk);
      #1;
      checks++;
      if (fp_out_valid !== 1'b1 || fp_out_sel !== 2'd1 || fp_out_data !== 8'h41)
        $display("FAIL fp_out cycle%0d: got v=%b s=%0d d=%h, required v=1 s=1 d=41", k, fp_out_valid, fp_out_sel, fp_out_data);
      else passes++;
    end
    fp_valid = 4'b1000;
    @(negedge clk);
    checks++;
    if (fp_ready !== 4'b1000) $display("FAIL fp_ready_ch3: got %b, required 1000", fp_ready);
    else passes++;
    @(posedge clk);
    #1;
    checks++;
    if (fp_out_sel !== 2'd3 || fp_out_data !== 8'h43)
      $display("FAIL fp_out_ch3: got s=%0d d=%h, required s=3 d=43", fp_out_sel, fp_out_data);
    else passes++;
    fp_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    en = 4'hF;
    push_beat(1, 8'h05, 1'b0);
    push_beat(1, 8'h06, 1'b0);
    push_beat(1, 8'h07, 1'b1);
    push_beat(3, 8'h99, 1'b1);
    step();
    tb_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h05 || out_sel !== 2'd1 || last_rdy !== 4'b0)
        $display("FAIL bp_hold cycle%0d: got v=%b d=%h s=%0d rdy=%b, required v=1 d=05 s=1 rdy=0000",
                 k, out_valid, out_data, out_sel, last_rdy);
      else passes++;
    end
    tb_ready = 1'b1;
    drain_and_check("bp");
  endtask

  task automatic test_packet_lock();
    do_reset();
    en = 4'b0001;
    push_beat(0, 8'hC0, 1'b0);
    push_beat(0, 8'hC1, 1'b0);
    push_beat(0, 8'hC2, 1'b0);
    push_beat(0, 8'hC3, 1'b1);
    push_beat(1, 8'hD0, 1'b0);
    push_beat(1, 8'hD1, 1'b1);
`ifdef STREAM_MUX_PKT_LOCK_EN
    for (int k = 0; k < 4; k++) order_q.push_back(0);
    for (int k = 0; k < 2; k++) order_q.push_back(1);
`endif
    step();
    step();
    en = 4'b0011;
    step();
    en = 4'b0010;
    for (int k = 0; k < 2; k++) begin
      step();
`ifdef STREAM_MUX_PKT_LOCK_EN
      checks++;
      if (last_rdy !== 4'b0) $display("FAIL lock_hold cycle%0d: got rdy=%b, required 0000", k, last_rdy);
      else passes++;
`endif
    end
    drain_and_check("lock");
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    en = 4'hF;
    push_beat(2, 8'h21, 1'b0);
    push_beat(2, 8'h22, 1'b0);
    push_beat(2, 8'h23, 1'b1);
    step();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || out_sel !== 2'd0)
      $display("FAIL midrst_out: got v=%b s=%0d, required v=0 s=0", out_valid, out_sel);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
    end
    order_q.delete();
    for (int i = 0; i < 4; i++) begin
      push_beat(i, 8'hE0 + 8'(i), 1'b1);
      order_q.push_back(i);
    end
    drain_and_check("midrst");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_channel();
    test_round_robin();
    test_fixed_priority();
    test_backpressure();
    test_packet_lock();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
